// File: rtl/i4001_rom_arbiter.sv
// Arbitrates the single-port i4001 ROM RAM between CPU fetch and host loader/debug access.
// Define I4001_ROM_WRPROT_EN to add wr_protect/host_err for blocking host writes.
module i4001_rom_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
`ifdef I4001_ROM_WRPROT_EN
  input  logic              wr_protect,
  output logic              host_err,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // state | meaning
  // CPU   | RAM serves cpu_addr; steal allowed once address is stable
  // HOST  | RAM serves the host access for one cycle (host_gnt)
  // RSP   | RAM back on cpu_addr; host read data arrives on ram_rdata
  typedef enum logic [1:0] {ST_CPU = 2'd0, ST_HOST = 2'd1, ST_RSP = 2'd2} state_t;

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  stable_cnt;
  logic [ADDR_W-1:0] cpu_addr_q;
  logic              cap_pend;
  logic              rd_pend;
  logic              wr_blocked;

`ifdef I4001_ROM_WRPROT_EN
  assign wr_blocked = wr_protect;
`else
  assign wr_blocked = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) state <= ST_CPU;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_CPU:  if (host_req && stable_cnt == CNT_MAX) state_nxt = ST_HOST;
      ST_HOST: state_nxt = ST_RSP;
      ST_RSP:  state_nxt = ST_CPU;
      default: state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_we   = 1'b0;
    host_gnt = 1'b0;
`ifdef I4001_ROM_WRPROT_EN
    host_err = 1'b0;
`endif
    if (state == ST_HOST) begin
      ram_addr = host_addr;
      ram_we   = host_we && !wr_blocked;
      host_gnt = 1'b1;
`ifdef I4001_ROM_WRPROT_EN
      host_err = host_we && wr_protect;
`endif
    end
  end

  assign ram_wdata = host_wdata;

  // ram_rdata carries a CPU word in every cycle except the one right after HOST,
  // so cap_pend only blocks capture during RSP.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      cpu_addr_q  <= '0;
      stable_cnt  <= '0;
      cap_pend    <= 1'b0;
      rd_pend     <= 1'b0;
      cpu_data    <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      cpu_addr_q <= cpu_addr;
      if (state != ST_CPU || state_nxt == ST_HOST || cpu_addr != cpu_addr_q)
        stable_cnt <= '0;
      else if (stable_cnt != CNT_MAX)
        stable_cnt <= stable_cnt + 1'b1;
      cap_pend <= (state != ST_HOST);
      if (cap_pend) cpu_data <= ram_rdata;
      if (state == ST_HOST) rd_pend <= !host_we;
      host_rvalid <= (state == ST_RSP) && rd_pend;
      if (state == ST_RSP && rd_pend) host_rdata <= ram_rdata;
    end
  end

endmodule

// File: doc/i4001_rom_arbiter.md
Name: i4001_rom_arbiter

Overview:
- Owns the single-port synchronous block RAM that backs the shared i4001 ROM address/data bus.
- Serves the wired-OR CPU fetch address continuously.
- Steals idle RAM cycles for a host loader/debug port (read/write) without disturbing fetch data.
- Sits between the i4001 rom_addr/rom_data bus, the i4001_rom storage array and the host loader.

Parameters:
ADDR_W, 12, RAM address width ({ROM_NUMBER, 8-bit offset})
DATA_W, 8, RAM word width
STABLE_CYCLES, 2, consecutive cycles cpu_addr must be unchanged before a host steal is allowed (min 2)

Ports:
sysclk  in  1  system clock; all logic on rising edge
poc_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  fetch address from i4001 rom_addr bus
cpu_data  out  DATA_W  fetch data to i4001 rom_data inputs
host_req  in  1  host access request; held with addr/we/wdata until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse: host access issued to RAM this cycle
host_rdata  out  DATA_W  host read data, valid while host_rvalid
host_rvalid  out  1  one-cycle pulse, two cycles after host_gnt for reads
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency

Behaviour:
Reset:
- Asynchronous on poc_n low.
- state=CPU; cpu_data, host_rdata, stable_cnt, cpu_addr_q = 0.
- host_gnt, host_rvalid, ram_we, cap_pend = 0.

Address tracking:
- cpu_addr_q <= cpu_addr every cycle.
- stable_cnt: 0 when cpu_addr != cpu_addr_q; otherwise increments, saturating at STABLE_CYCLES.
- stable_cnt is forced to 0 on entry to HOST.

States:
- CPU: ram_addr=cpu_addr, ram_we=0. cap_pend <= 1. When cap_pend=1, cpu_data <= ram_rdata.
  - Fetch latency: cpu_data reflects a new cpu_addr 2 cycles after the address changes.
  - Leave for HOST when host_req=1 and stable_cnt==STABLE_CYCLES.
- HOST (1 cycle):
  - ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata, host_gnt=1.
  - cpu_data capture from this cycle's ram_rdata still allowed (it carries the CPU word).
  - Unconditionally goes to RSP.
- RSP (1 cycle):
  - ram_addr=cpu_addr, ram_we=0. cap_pend <= 0 for one cycle, so cpu_data is not updated from host read data.
  - If the access was a read: host_rdata <= ram_rdata; host_rvalid=1 on the following cycle.
  - Returns to CPU.

Boundary conditions:
- cpu_addr changes during HOST/RSP: cpu_data holds its old value until the normal re-read completes (worst-case latency 4 cycles).
- Host write to the current cpu_addr: cpu_data shows the new word no later than 3 cycles after host_gnt.
- Back-to-back host requests: steals are separated by at least STABLE_CYCLES+1 CPU cycles. The CPU always has priority; a continuously changing cpu_addr starves the host, by design.
- host_req dropped before host_gnt: no access, no pulses.
- Reset mid-access: the access is abandoned; no rvalid follows.
- Write accesses never produce host_rvalid.

Optional Feature:
I4001_ROM_WRPROT_EN:
- Defined:
  - Adds input wr_protect (1 bit) and output host_err (1 bit, reset 0).
  - A host write while wr_protect=1 is still granted, but ram_we is held 0.
  - host_err pulses for 1 cycle, coincident with host_gnt.
  - Reads are unaffected.
- Undefined: both ports are absent and all host writes reach the RAM.

Test Plan:
- Reset with poc_n=0, then release; cpu_addr=12'h000, RAM[0]=8'hA5 -> cpu_data=8'hA5 by cycle 2; host_gnt and host_rvalid stay 0.
- cpu_addr held at 12'h123 (RAM=8'h3C); host read of 12'h7FF (RAM=8'h81) -> host_gnt once stable_cnt reaches 2; host_rvalid with host_rdata=8'h81 two cycles later; cpu_data stays 8'h3C throughout.
- Host write 8'h5A to 12'h123 while cpu_addr=12'h123 (old value 8'h3C) -> ram_we for 1 cycle; cpu_data goes 8'h3C->8'h5A within 3 cycles of host_gnt; no host_rvalid.
- cpu_addr incrementing every cycle with host_req=1 -> no host_gnt; hold cpu_addr for 2 cycles -> exactly one host_gnt.
- cpu_addr changes in the HOST cycle -> cpu_data updates to the new address word within 4 cycles; never shows host read data.
- With I4001_ROM_WRPROT_EN and wr_protect=1, host write 8'hFF to 12'h010 -> host_gnt and host_err pulse together; RAM[12'h010] unchanged (verify by a later host read).
